// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The full result is computed at issue, then held for a fixed latency before it commits to HI/LO.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [2:0]  MDUOp,
    input  logic        Start,
    input  logic        RdSel,
    output logic        Busy,
    output logic [31:0] MDUResult
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        wr_q, wr_d;
    logic [63:0] issue_res;

    function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic signed [63:0] p;
        ea = $signed({{32{a[31]}}, a});
        eb = $signed({{32{b[31]}}, b});
        p  = ea * eb;
        return p;
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p;
    endfunction

    // Returns {remainder, quotient}; a zero divisor is replaced by 1 because that result is never committed.
    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = (b == 32'd0) ? 32'd1 : b;
        return {a % d, a / d};
    endfunction

    // Magnitude division with sign fix-up: quotient truncates toward zero, remainder follows the dividend.
    // Working in unsigned magnitudes makes 0x80000000 / -1 wrap to 0x80000000 instead of overflowing.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = a[31] ? (~a + 32'd1) : a;
        mb = b[31] ? (~b + 32'd1) : b;
        {r, q} = div_unsigned(ma, mb);
        if (a[31] ^ b[31]) begin
            q = ~q + 32'd1;
        end
        if (a[31]) begin
            r = ~r + 32'd1;
        end
        return {r, q};
    endfunction

    always_comb begin
        issue_res = 64'd0;
        case (MDUOp)
            OP_MULT:  issue_res = mul_signed(SrcA, SrcB);
            OP_MULTU: issue_res = mul_unsigned(SrcA, SrcB);
            OP_DIV:   issue_res = div_signed(SrcA, SrcB);
            OP_DIVU:  issue_res = div_unsigned(SrcA, SrcB);
            default:  issue_res = 64'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        wr_d     = wr_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            {res_hi_d, res_lo_d} = issue_res;
                            cnt_d   = MULT_LOAD;
                            wr_d    = 1'b1;
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            {res_hi_d, res_lo_d} = issue_res;
                            cnt_d   = DIV_LOAD;
                            wr_d    = (SrcB != 32'd0);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = SrcA;
                        OP_MTLO: lo_d = SrcA;
                        default: ;
                    endcase
                end
            end
            default: begin
                // Start is deliberately ignored here; at most one operation is outstanding.
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    if (wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            wr_q     <= wr_d;
        end
    end

    assign Busy      = (state_q == S_RUN);
    assign MDUResult = RdSel ? hi_q : lo_q;

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the combinational ALU.
- Accepts MIPS mult/multu/div/divu, mthi/mtlo and mfhi/mflo requests from the pipeline, and owns the HI and LO architectural registers.
- Asserts Busy while an operation is in flight so the hazard unit can stall any later MDU instruction.
- Its read port (MDUResult) feeds the EX result mux alongside ALUResult.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, number of Busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- SrcA  input  32  operand A: dividend or multiplicand, or the value for mthi/mtlo.
- SrcB  input  32  operand B: divisor or multiplier.
- MDUOp  input  3  operation select: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- Start  input  1  request strobe; MDUOp is acted on only in a cycle where Start=1.
- RdSel  input  1  read select: 0 selects LO, 1 selects HI.
- Busy  output  1  high while a mult/div is in flight.
- MDUResult  output  32  RdSel ? HI : LO; combinational from the HI/LO registers.

Behaviour:
- Reset: asynchronous while rst_n=0. HI=0, LO=0, Busy=0, state IDLE, counter=0, internal result latches=0. MDUResult=0 during reset.
- States: IDLE and RUN. The counter is 4 bits.
- IDLE with Start=1 and MDUOp in {1,2,3,4}:
  - Operands are latched at this clock edge and the full 64-bit result is computed into internal registers.
  - Counter loads MULT_CYCLES-1 or DIV_CYCLES-1; state goes to RUN.
  - Busy goes high from the next cycle.
- RUN: the counter decrements each cycle. At the edge where counter==0:
  - HI and LO are committed; state returns to IDLE; Busy falls.
  - Busy is therefore high for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - The new HI/LO are visible on MDUResult in the first cycle after Busy falls.
- HI/LO hold their old values throughout RUN, and MDUResult reflects the old values during that time.
- MULT: signed 32x32 to 64 bits; HI = product[63:32], LO = product[31:0]. MULTU is the same, unsigned.
- DIV (signed):
  - LO = quotient, truncated toward zero.
  - HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (SrcB=0 for DIV or DIVU):
  - Busy still runs the full DIV_CYCLES.
  - At commit, HI and LO are left unchanged.
- MTHI / MTLO in IDLE: HI or LO (respectively) takes SrcA at the same edge. Busy is never raised.
- Any Start while in RUN (any MDUOp) is ignored; HI/LO/state are unaffected. The hazard unit is required never to do this. Busy is never extended.
- NOP, reserved opcodes, and Start=0 have no effect.
- Reset mid-operation: the operation is aborted immediately; HI=LO=0 and Busy=0; no late commit occurs.
- The unit does not pipeline or overlap operations; at most one is outstanding.

Test Plan:
- Reset → HI=LO=0, Busy=0, MDUResult=0 for both values of RdSel.
- MULT with SrcA=0xFFFFFFFE (-2), SrcB=3 → Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV with SrcA=-7 (0xFFFFFFF9), SrcB=2 → Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- MTHI SrcA=0x12345678, then DIVU x/0 → Busy for 10 cycles, HI stays 0x12345678, LO stays at its prior value.
- During a MULT in RUN, issue Start with MTLO SrcA=0xDEAD and Start with DIV → both ignored; the original MULT commits at cycle 5; LO is not 0xDEAD.
- Pulse rst_n low at cycle 3 of a DIV → HI=LO=0 and Busy=0 immediately; no update follows in later cycles.
